// File: rtl/pulse_gate_sequencer.sv
// Gated photon-count window sequencer: start, programmable delay, then N x (gate, report), then done.
// Optional inter-window holdoff under `PULSE_GATE_HOLDOFF_EN; a stalled result port stretches the run.
module pulse_gate_sequencer #(
  parameter int COUNT_WIDTH = 32,
  parameter int TIMER_WIDTH = 32,
  parameter int INDEX_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [TIMER_WIDTH-1:0] cfg_delay,
  input  logic [TIMER_WIDTH-1:0] cfg_gate,
  input  logic [INDEX_WIDTH-1:0] cfg_windows,
`ifdef PULSE_GATE_HOLDOFF_EN
  input  logic [TIMER_WIDTH-1:0] cfg_holdoff,
`endif
  input  logic                   edge_in,
  output logic                   gate_out,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] result_count,
  output logic [INDEX_WIDTH-1:0] result_index,
  output logic                   result_overflow,
  output logic                   result_tvalid,
  input  logic                   result_tready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_GATE,
`ifdef PULSE_GATE_HOLDOFF_EN
    S_HOLDOFF,
`endif
    S_REPORT
  } state_t;

  localparam logic [TIMER_WIDTH-1:0] TIMER_ONE = TIMER_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);
  localparam logic [INDEX_WIDTH-1:0] INDEX_ONE = INDEX_WIDTH'(1);

  state_t                 state, state_nxt;
  logic [TIMER_WIDTH-1:0] timer, timer_nxt;
  logic [COUNT_WIDTH-1:0] count, count_nxt;
  logic                   ovf, ovf_nxt;
  logic [INDEX_WIDTH-1:0] index, index_nxt;
  logic [TIMER_WIDTH-1:0] sh_gate, sh_gate_nxt;
  logic [INDEX_WIDTH-1:0] sh_win, sh_win_nxt;
`ifdef PULSE_GATE_HOLDOFF_EN
  logic [TIMER_WIDTH-1:0] sh_holdoff, sh_holdoff_nxt;
`endif
  logic                   gate_nxt, done_nxt, tvalid_nxt, rovf_nxt;
  logic [COUNT_WIDTH-1:0] rcount_nxt;
  logic [INDEX_WIDTH-1:0] rindex_nxt;
  logic [COUNT_WIDTH-1:0] sat_count;
  logic                   sat_ovf;
  logic                   open_req;
  logic                   more_windows;

  assign busy = (state != S_IDLE);
  // sh_win is at least 1 once a run is latched, so the subtraction cannot wrap.
  assign more_windows = (index < (sh_win - INDEX_ONE));

  always_comb begin
    sat_count = count;
    sat_ovf   = ovf;
    if (edge_in) begin
      if (&count) sat_ovf = 1'b1;
      else        sat_count = count + COUNT_ONE;
    end
  end

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    count_nxt   = count;
    ovf_nxt     = ovf;
    index_nxt   = index;
    sh_gate_nxt = sh_gate;
    sh_win_nxt  = sh_win;
`ifdef PULSE_GATE_HOLDOFF_EN
    sh_holdoff_nxt = sh_holdoff;
`endif
    gate_nxt    = gate_out;
    done_nxt    = 1'b0;
    tvalid_nxt  = result_tvalid;
    rcount_nxt  = result_count;
    rindex_nxt  = result_index;
    rovf_nxt    = result_overflow;
    open_req    = 1'b0;

    if (abort) begin
      state_nxt  = S_IDLE;
      timer_nxt  = '0;
      gate_nxt   = 1'b0;
      tvalid_nxt = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sh_gate_nxt = (cfg_gate == '0) ? TIMER_ONE : cfg_gate;
            sh_win_nxt  = (cfg_windows == '0) ? INDEX_ONE : cfg_windows;
`ifdef PULSE_GATE_HOLDOFF_EN
            sh_holdoff_nxt = cfg_holdoff;
`endif
            index_nxt = '0;
            if (cfg_delay != '0) begin
              state_nxt = S_DELAY;
              timer_nxt = cfg_delay - TIMER_ONE;
            end else begin
              state_nxt = S_GATE;
              timer_nxt = '0;
            end
          end
        end
        S_DELAY: begin
          if (timer == '0) state_nxt = S_GATE;
          else             timer_nxt = timer - TIMER_ONE;
        end
        S_GATE: begin
          // First GATE cycle after start/delay keeps the gate shut for one cycle.
          if (!gate_out) begin
            open_req = 1'b1;
          end else if (timer == '0) begin
            rcount_nxt = sat_count;
            rovf_nxt   = sat_ovf;
            rindex_nxt = index;
            tvalid_nxt = 1'b1;
            gate_nxt   = 1'b0;
            count_nxt  = sat_count;
            ovf_nxt    = sat_ovf;
            state_nxt  = S_REPORT;
          end else begin
            count_nxt = sat_count;
            ovf_nxt   = sat_ovf;
            timer_nxt = timer - TIMER_ONE;
          end
        end
`ifdef PULSE_GATE_HOLDOFF_EN
        S_HOLDOFF: begin
          if (timer == '0) open_req = 1'b1;
          else             timer_nxt = timer - TIMER_ONE;
        end
`endif
        S_REPORT: begin
          if (result_tready) begin
            tvalid_nxt = 1'b0;
            if (more_windows) begin
              index_nxt = index + INDEX_ONE;
`ifdef PULSE_GATE_HOLDOFF_EN
              if (sh_holdoff != '0) begin
                state_nxt = S_HOLDOFF;
                timer_nxt = sh_holdoff - TIMER_ONE;
              end else begin
                open_req = 1'b1;
              end
`else
              open_req = 1'b1;
`endif
            end else begin
              done_nxt  = 1'b1;
              state_nxt = S_IDLE;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase

      if (open_req) begin
        state_nxt = S_GATE;
        gate_nxt  = 1'b1;
        timer_nxt = sh_gate - TIMER_ONE;
        count_nxt = '0;
        ovf_nxt   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      timer           <= '0;
      count           <= '0;
      ovf             <= 1'b0;
      index           <= '0;
      sh_gate         <= '0;
      sh_win          <= '0;
`ifdef PULSE_GATE_HOLDOFF_EN
      sh_holdoff      <= '0;
`endif
      gate_out        <= 1'b0;
      done            <= 1'b0;
      result_tvalid   <= 1'b0;
      result_count    <= '0;
      result_index    <= '0;
      result_overflow <= 1'b0;
    end else begin
      state           <= state_nxt;
      timer           <= timer_nxt;
      count           <= count_nxt;
      ovf             <= ovf_nxt;
      index           <= index_nxt;
      sh_gate         <= sh_gate_nxt;
      sh_win          <= sh_win_nxt;
`ifdef PULSE_GATE_HOLDOFF_EN
      sh_holdoff      <= sh_holdoff_nxt;
`endif
      gate_out        <= gate_nxt;
      done            <= done_nxt;
      result_tvalid   <= tvalid_nxt;
      result_count    <= rcount_nxt;
      result_index    <= rindex_nxt;
      result_overflow <= rovf_nxt;
    end
  end

endmodule
